// File: rtl/bht_update_queue_if.sv
// Push-side and BHT-update-side signals of bht_update_queue, with producer (master) and queue (slave) views.
interface bht_update_queue_if #(
  parameter int VLEN  = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush_i;
  logic            push_valid_i;
  logic [VLEN-1:0] push_pc_i;
  logic            push_taken_i;
  logic            hold_i;
  logic            bht_upd_valid_o;
  logic [VLEN-1:0] bht_upd_pc_o;
  logic            bht_upd_taken_o;
  logic [CW-1:0]   count_o;
  logic            full_o;
  logic [CNT_W-1:0] drop_cnt_o;

  modport master (
    output flush_i, push_valid_i, push_pc_i, push_taken_i, hold_i,
    input  bht_upd_valid_o, bht_upd_pc_o, bht_upd_taken_o, count_o, full_o, drop_cnt_o
  );

  modport slave (
    input  flush_i, push_valid_i, push_pc_i, push_taken_i, hold_i,
    output bht_upd_valid_o, bht_upd_pc_o, bht_upd_taken_o, count_o, full_o, drop_cnt_o
  );
endinterface

// File: rtl/bht_update_queue.sv
// FIFO of branch-resolution updates drained one per cycle into the BHT update port.
// Optional feature macro: BHT_UPD_STATS_EN enables the saturating dropped-push counter.
module bht_update_queue #(
  parameter int VLEN  = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  bht_update_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [VLEN-1:0]  pc_mem [DEPTH];
  logic [DEPTH-1:0] taken_mem;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             pop;
  logic             push;

  // A flush cycle presents nothing, so the head is never consumed while being discarded.
  assign full = (count == CW'(DEPTH));
  assign pop  = (count != '0) && !bus.hold_i && !bus.flush_i;
  assign push = bus.push_valid_i && (!full || pop);

  assign bus.bht_upd_valid_o = pop;
  assign bus.bht_upd_pc_o    = pc_mem[rd_ptr];
  assign bus.bht_upd_taken_o = taken_mem[rd_ptr];
  assign bus.count_o         = count;
  assign bus.full_o          = full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      taken_mem <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i] <= '0;
      end
    end else if (bus.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= bus.push_pc_i;
        taken_mem[wr_ptr] <= bus.push_taken_i;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

`ifdef BHT_UPD_STATS_EN
  logic [CNT_W-1:0] drop_cnt;
  logic             drop;

  // Pushes discarded by a flush are not drops; only a full queue with no pop loses one.
  assign drop = bus.push_valid_i && full && !pop && !bus.flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  assign bus.drop_cnt_o = drop_cnt;
`else
  assign bus.drop_cnt_o = {CNT_W{1'b0}};
`endif
endmodule
